serial_operand_feeder: RTL and testbench



---
 rtl/serial_pkg.sv | 11 +
 rtl/serial_operand_feeder_shreg_piso.sv | 30 +++
 rtl/serial_operand_feeder.sv | 110 +++++++++++
 tb/tb_serial_operand_feeder.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared types and constants for the serial adder datapath (feeder and adder).
package serial_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int SERIAL_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/serial_operand_feeder_shreg_piso.sv
// shreg_piso: parallel-load, right-shift register that exposes only its LSB.
// Load takes priority over shift; zeros enter from the MSB side.
module shreg_piso
  import serial_pkg::*;
#(
  parameter int WIDTH = SERIAL_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             lsb
);

  logic [WIDTH-1:0] data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else if (load) begin
      data <= din;
    end else if (shift) begin
      data <= {1'b0, data[WIDTH-1:1]};
    end
  end

  assign lsb = data[0];

endmodule

// File: rtl/serial_operand_feeder.sv
// Parallel-to-serial front end of the serial adder: emits operand bit pairs LSB first.
// Optional subtract mode (sub_in, inverted B, cin_init=1) is enabled by SERIAL_FEEDER_SUB_EN.
module serial_operand_feeder
  import serial_pkg::*;
#(
  parameter int WIDTH = SERIAL_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
`ifdef SERIAL_FEEDER_SUB_EN
  input  logic             sub_in,
`endif
  output logic             bit_valid,
  input  logic             bit_ready,
  output logic             a_bit,
  output logic             b_bit,
  output logic             first_bit,
  output logic             last_bit,
  output logic             cin_init,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BEAT = CW'(WIDTH - 1);

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   count;
  logic            sub_flag;
  logic            accept;
  logic            beat_xfer;
  logic            a_lsb;
  logic            b_lsb;

  assign bit_valid = (state == SHIFT);
  assign busy      = (state == SHIFT);
  assign first_bit = bit_valid && (count == '0);
  assign last_bit  = bit_valid && (count == LAST_BEAT);
  assign beat_xfer = bit_valid && bit_ready;
  // Accepting during the final beat lets back-to-back words run without a bubble.
  assign in_ready  = (state == IDLE) || (last_bit && bit_ready);
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = SHIFT;
      SHIFT:   if (beat_xfer && last_bit && !accept) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The counter wraps to 0 on the last beat so it never exceeds WIDTH-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (accept) begin
      count <= '0;
    end else if (beat_xfer) begin
      count <= last_bit ? '0 : count + 1'b1;
    end
  end

`ifdef SERIAL_FEEDER_SUB_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_flag <= 1'b0;
    end else if (accept) begin
      sub_flag <= sub_in;
    end
  end
`else
  assign sub_flag = 1'b0;
`endif

  shreg_piso #(.WIDTH(WIDTH)) u_shreg_a (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .shift (beat_xfer),
    .din   (a_in),
    .lsb   (a_lsb)
  );

  shreg_piso #(.WIDTH(WIDTH)) u_shreg_b (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .shift (beat_xfer),
    .din   (b_in),
    .lsb   (b_lsb)
  );

  assign a_bit    = a_lsb;
  assign b_bit    = b_lsb ^ sub_flag;
  assign cin_init = sub_flag;

endmodule

// File: tb/tb_serial_operand_feeder.sv
// Scoreboard bench for serial_operand_feeder (WIDTH=8); the subtract case runs only
// when SERIAL_FEEDER_SUB_EN is defined.
module tb_serial_operand_feeder;

  localparam int W = 8;

  typedef struct packed {
    logic a;
    logic b;
    logic first;
    logic last;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
`ifdef SERIAL_FEEDER_SUB_EN
  logic         sub_in;
`endif
  logic         bit_valid;
  logic         bit_ready;
  logic         a_bit;
  logic         b_bit;
  logic         first_bit;
  logic         last_bit;
  logic         cin_init;
  logic         busy;

  int           checks = 0;
  int           errors = 0;
  int           beat_idx = 0;
  int           beats_done = 0;
  beat_t        exp_q[$];
  logic [W-1:0] sum_q[$];
  logic [W-1:0] acc;
  logic         carry;

  serial_operand_feeder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
`ifdef SERIAL_FEEDER_SUB_EN
    .sub_in    (sub_in),
`endif
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .a_bit     (a_bit),
    .b_bit     (b_bit),
    .first_bit (first_bit),
    .last_bit  (last_bit),
    .cin_init  (cin_init),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pops and compares the beat that transfers at the coming edge, and runs a serial adder model.
  task automatic check_output();
    beat_t e;
    logic  c_in;
    logic  s;
    if (bit_valid && bit_ready) begin
      if (exp_q.size() == 0) begin
        check("beat_unexpected", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("a_bit[%0d]", beat_idx), a_bit, e.a);
        check($sformatf("b_bit[%0d]", beat_idx), b_bit, e.b);
        check($sformatf("first_bit[%0d]", beat_idx), first_bit, e.first);
        check($sformatf("last_bit[%0d]", beat_idx), last_bit, e.last);
        c_in = (beat_idx == 0) ? cin_init : carry;
        s = a_bit ^ b_bit ^ c_in;
        carry = (a_bit & b_bit) | (c_in & (a_bit ^ b_bit));
        acc[beat_idx] = s;
        beat_idx++;
        beats_done++;
        if (e.last) begin
          check("word_sum", acc, sum_q.pop_front());
          beat_idx = 0;
        end
      end
    end
  endtask

  // Offers an operand pair at the current negedge; it must be accepted at the next edge.
  task automatic apply_stimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    in_valid = 1'b1;
    a_in     = a;
    b_in     = b;
`ifdef SERIAL_FEEDER_SUB_EN
    sub_in   = sub;
`endif
    #1;
    check("accept_ready", in_ready, 1'b1);
    for (int i = 0; i < W; i++) begin
      exp_q.push_back('{a: a[i], b: b[i] ^ sub, first: (i == 0), last: (i == W - 1)});
    end
    sum_q.push_back(sub ? a - b : a + b);
    check_output();
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("beat0_valid", bit_valid, 1'b1);
    check("beat0_first", first_bit, 1'b1);
    check("word_cin_init", cin_init, sub);
  endtask

  // Runs beats until only 'leave' expected beats remain, optionally stalling at one beat.
  task automatic drain(input int leave, input int stall_at, input int stall_len);
    int guard = 0;
    int stalled = 0;
    while (exp_q.size() > leave && guard < 64) begin
      if (beat_idx == stall_at && stalled < stall_len) begin
        bit_ready = 1'b0;
        stalled++;
        #1;
        check("stall_valid", bit_valid, 1'b1);
        check("stall_a_hold", a_bit, exp_q[0].a);
        check("stall_b_hold", b_bit, exp_q[0].b);
        check("stall_first", first_bit, exp_q[0].first);
      end else begin
        bit_ready = 1'b1;
        #1;
        check_output();
      end
      @(negedge clk);
      guard++;
    end
    bit_ready = 1'b1;
    if (guard >= 64) check("drain_timeout", 64'(guard), 64'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a_in      = '0;
    b_in      = '0;
`ifdef SERIAL_FEEDER_SUB_EN
    sub_in    = 1'b0;
`endif
    bit_ready = 1'b1;
    carry     = 1'b0;
    acc       = '0;

    @(negedge clk);
    #1;
    check("rst_bit_valid", bit_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_first", first_bit, 1'b0);
    check("rst_last", last_bit, 1'b0);
    check("rst_a_bit", a_bit, 1'b0);
    check("rst_b_bit", b_bit, 1'b0);
    check("rst_cin", cin_init, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);

    $display("[TB] single word");
    beats_done = 0;
    apply_stimulus(8'h5A, 8'h3C, 1'b0);
    drain(0, -1, 0);
    #1;
    check("single_beats", 64'(beats_done), 64'd8);
    check("single_idle_valid", bit_valid, 1'b0);
    check("single_idle_busy", busy, 1'b0);
    check("single_idle_ready", in_ready, 1'b1);
    @(negedge clk);

    $display("[TB] stall");
    beats_done = 0;
    apply_stimulus(8'h5A, 8'h3C, 1'b0);
    drain(0, 2, 3);
    check("stall_beats", 64'(beats_done), 64'd8);
    @(negedge clk);

    $display("[TB] back-to-back");
    apply_stimulus(8'h12, 8'h34, 1'b0);
    drain(1, -1, 0);
    #1;
    check("b2b_last", last_bit, 1'b1);
    apply_stimulus(8'hFF, 8'h01, 1'b0);
    check("b2b_a_bit", a_bit, 1'b1);
    check("b2b_b_bit", b_bit, 1'b1);
    drain(0, -1, 0);
    @(negedge clk);

    $display("[TB] ignored offer");
    apply_stimulus(8'h96, 8'h69, 1'b0);
    drain(W - 4, -1, 0);
    in_valid = 1'b1;
    a_in     = 8'h00;
    b_in     = 8'hFF;
    #1;
    check("ignored_ready", in_ready, 1'b0);
    check_output();
    @(negedge clk);
    in_valid = 1'b0;
    drain(0, -1, 0);
    @(negedge clk);

    $display("[TB] reset mid-word");
    apply_stimulus(8'hF0, 8'h0F, 1'b0);
    drain(W - 4, -1, 0);
    #1;
    check("pre_rst_a_bit", a_bit, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", bit_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_a_bit", a_bit, 1'b0);
    exp_q.delete();
    sum_q.delete();
    beat_idx = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("postrst_ready", in_ready, 1'b1);
    @(negedge clk);
    beats_done = 0;
    apply_stimulus(8'hC3, 8'h81, 1'b0);
    drain(0, -1, 0);
    check("postrst_beats", 64'(beats_done), 64'd8);
    @(negedge clk);

`ifdef SERIAL_FEEDER_SUB_EN
    $display("[TB] subtract");
    apply_stimulus(8'h05, 8'h03, 1'b1);
    drain(0, -1, 0);
    @(negedge clk);
`endif

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
